sel_demux: RTL and testbench
============================

// Module: sel_demux
// PURPOSE
//  Clocked 1:2 demultiplexer; the inverse of the select-controlled 2:1 mux (z = c ? b : a).
//  - One input stream is routed by in_sel to output 0 (sel=0, the "a" leg) or output 1 (sel=1, the "b" leg).
//  - Each output leg has a one-entry registered slot with a valid/ready handshake.
//  - Each leg has a wrapping count of accepted items.
//  - Sits between a producer and two consumers; also serves as the mux DUT's round-trip partner in loopback benches.
// PARAMETERS
//  W      1  data width of in_data/out*_data
//  CNT_W  8  width of per-leg accepted-item counters
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      producer has an item
//  in_ready    out  1      item accepted this cycle when in_valid && in_ready
//  in_data     in   W      item payload
//  in_sel      in   1      destination leg (0 or 1); sampled only when in_valid=1
//  out0_valid  out  1      leg-0 slot holds an item
//  out0_ready  in   1      leg-0 consumer takes the item
//  out0_data   out  W      leg-0 payload
//  out1_valid  out  1      leg-1 slot holds an item
//  out1_ready  in   1      leg-1 consumer takes the item
//  out1_data   out  W      leg-1 payload
//  cnt0        out  CNT_W  items accepted into leg 0
//  cnt1        out  CNT_W  items accepted into leg 1
//  busy        out  1      out0_valid | out1_valid
// BEHAVIOUR
//  - Reset (async assert, sync release): all out*_valid=0, out*_data=0, cnt0=cnt1=0, busy=0. Any buffered item is discarded.
//  - Per-leg slot state is EMPTY or FULL.
//    - EMPTY -> FULL on load.
//    - FULL -> EMPTY on drain (out_valid && out_ready) without load.
//    - FULL -> FULL on simultaneous drain + load: the new data replaces the old; no bubble, no loss.
//  - in_ready is combinational: in_ready = !outS_valid || outS_ready, where S = in_sel.
//    - It must not depend on in_valid.
//    - in_ready toward leg S ignores the state of the other leg; no head-of-line coupling beyond the selected leg.
//  - Accept (in_valid && in_ready) loads slot[in_sel] with in_data. outS_valid=1 on the next edge; latency is 1 cycle.
//  - Throughput is 1 item/cycle per leg when its consumer holds ready=1.
//  - A full leg with ready=0 holds data and valid stable until drained.
//  - Unselected leg: unaffected by the accept; it drains independently the same cycle.
//  - in_sel/in_data are don't-care while in_valid=0; no state changes.
//  - cntS increments by 1 on each accept into leg S and wraps from 2^CNT_W-1 to 0 silently.
//  - Outputs are driven from registers only (except in_ready). No combinational path from in_data to out*_data.
//  - Reset mid-transfer: the item accepted in the reset cycle is lost; the producer re-sends after rst_n rises.
// STRUCTURE
//  - Package sel_demux_pkg holds:
//    - localparams LEG0=1'b0 and LEG1=1'b1
//    - typedef leg_t (1-bit)
//    - slot-state enum {SLOT_EMPTY, SLOT_FULL}
//  - Sub-module demux_slot (params W, CNT_W): one-entry register slice plus its counter.
//    - Ports: clk, rst_n, load, ld_data, ready, valid, data, cnt, can_load.
//    - Instantiated twice.
//  - Top holds only select decode, in_ready mux and busy.
// TESTING
//  - Reset: hold rst_n=0 with in_valid=1 -> out0/1_valid=0, cnt0=cnt1=0, busy=0; no accept.
//  - Route: send data=1,sel=0 then data=0,sel=1 (both readies=1) -> out0_data=1 at cycle+1, out1_data=0 at cycle+2; cnt0=1, cnt1=1.
//  - Backpressure: out0_ready=0, send sel=0 x2 -> first accepted, in_ready=0 for the second.
//    - Then raise out0_ready -> the second is accepted the same cycle; no loss, in order.
//  - Independence: leg 0 full/stalled, send sel=1 -> in_ready=1, out1_valid=1 next cycle, leg 0 unchanged.
//  - Wrap: CNT_W=2, 5 accepts to leg 1 -> cnt1 sequence 1,2,3,0,1.
//  - Mux loopback: feed out0_data/out1_data to a 2:1 mux (a,b) with c=in_sel.
//    - Sweep all 8 {a,b,c} -> mux z equals (c&b)|(a&~c) each cycle.
//  - Async reset with both legs full -> valids drop immediately, before the next clk edge.

Source files
------------

// File: rtl/sel_demux_pkg.sv
// Shared types for the clocked 1:2 select demultiplexer: leg identifiers and
// the per-leg slot state.
package sel_demux_pkg;

    localparam logic LEG0 = 1'b0;
    localparam logic LEG1 = 1'b1;

    typedef logic leg_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/sel_demux_if.sv
// Bundle of the producer-side stream, the two consumer legs, the counters and
// the per-leg slot state.
interface sel_demux_if #(
    parameter int W     = 1,
    parameter int CNT_W = 8
) ();
    import sel_demux_pkg::*;

    // Valid/ready: a transfer happens on a rising edge where valid && ready.
    // Valid never waits on ready. Once raised, valid and data hold until the
    // transfer. The ready signals may depend on the leg's own state but never
    // on valid.
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    leg_t             in_sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [W-1:0]     out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [W-1:0]     out1_data;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             busy;
    slot_state_e      dbg_st0;
    slot_state_e      dbg_st1;

    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data,
        output cnt0, cnt1, busy, dbg_st0, dbg_st1
    );

    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data,
        input  cnt0, cnt1, busy, dbg_st0, dbg_st1
    );

endinterface

// File: rtl/demux_slot.sv
// One-entry registered slot with a valid/ready output and a wrapping count of
// the items loaded into it.
module demux_slot
    import sel_demux_pkg::*;
#(
    parameter int W     = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     ld_data,
    input  logic             ready,
    output logic             valid,
    output logic [W-1:0]     data,
    output logic [CNT_W-1:0] cnt,
    output logic             can_load,
    output slot_state_e      state
);

    assign valid    = (state == SLOT_FULL);
    // A full slot can take a new item in the same cycle it is being drained.
    assign can_load = (state == SLOT_EMPTY) || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
            data  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: if (load) state <= SLOT_FULL;
                SLOT_FULL:  if (!load && ready) state <= SLOT_EMPTY;
            endcase
            if (load) begin
                data <= ld_data;
                cnt  <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sel_demux.sv
// Clocked 1:2 demultiplexer: in_sel steers each accepted item into leg 0 or
// leg 1, each leg buffering one item behind its own handshake.
module sel_demux
    import sel_demux_pkg::*;
#(
    parameter int W     = 1,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    sel_demux_if.slave bus
);

    logic can_load0;
    logic can_load1;
    logic in_ready;
    logic accept;
    logic load0;
    logic load1;

    // Readiness looks only at the selected leg, so a stalled leg never blocks the other.
    assign in_ready     = (bus.in_sel == LEG1) ? can_load1 : can_load0;
    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid && in_ready;
    assign load0        = accept && (bus.in_sel == LEG0);
    assign load1        = accept && (bus.in_sel == LEG1);
    assign bus.busy     = bus.out0_valid | bus.out1_valid;

    demux_slot #(.W(W), .CNT_W(CNT_W)) u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load0),
        .ld_data  (bus.in_data),
        .ready    (bus.out0_ready),
        .valid    (bus.out0_valid),
        .data     (bus.out0_data),
        .cnt      (bus.cnt0),
        .can_load (can_load0),
        .state    (bus.dbg_st0)
    );

    demux_slot #(.W(W), .CNT_W(CNT_W)) u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load1),
        .ld_data  (bus.in_data),
        .ready    (bus.out1_ready),
        .valid    (bus.out1_valid),
        .data     (bus.out1_data),
        .cnt      (bus.cnt1),
        .can_load (can_load1),
        .state    (bus.dbg_st1)
    );

endmodule

// File: tb/tb_sel_demux.sv
// Directed bench for sel_demux: routing, backpressure, leg independence,
// counter wrap, mux loopback and asynchronous reset.
module tb_sel_demux;
    import sel_demux_pkg::*;

    localparam int W     = 1;
    localparam int CNT_W = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    logic [W-1:0] e0;
    logic [W-1:0] e1;

    logic [CNT_W-1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    sel_demux_if #(.W(W), .CNT_W(CNT_W)) bus ();

    sel_demux #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected %0d tests to finish", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Records any accept that the coming edge performs, then advances one cycle.
    task automatic step();
        #1;
        if (rst_n && bus.in_valid && bus.in_ready) begin
            if (bus.in_sel) exp1_q.push_back(bus.in_data);
            else            exp0_q.push_back(bus.in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // scoreboard: every drain must deliver the oldest outstanding item of its leg
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out0_valid && bus.out0_ready) begin
                check("drain0_pending", exp0_q.size() != 0, 1);
                if (exp0_q.size() != 0) begin
                    e0 = exp0_q.pop_front();
                    check("drain0_data", bus.out0_data, e0);
                end
            end
            if (bus.out1_valid && bus.out1_ready) begin
                check("drain1_pending", exp1_q.size() != 0, 1);
                if (exp1_q.size() != 0) begin
                    e1 = exp1_q.pop_front();
                    check("drain1_data", bus.out1_data, e1);
                end
            end
        end
    end

    initial begin
        logic a, b, c, z, exp_z;
        logic [2:0] vb;

        // reset held with a pending item
        bus.in_valid   = 1'b1;
        bus.in_data    = 1'b1;
        bus.in_sel     = LEG0;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_v0",   bus.out0_valid, 0);
        check("rst_v1",   bus.out1_valid, 0);
        check("rst_d0",   bus.out0_data,  0);
        check("rst_cnt0", bus.cnt0,       0);
        check("rst_cnt1", bus.cnt1,       0);
        check("rst_busy", bus.busy,       0);
        check("rst_st0",  bus.dbg_st0,    SLOT_EMPTY);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_rst_cnt0", bus.cnt0,       0);
        check("post_rst_v0",   bus.out0_valid, 0);

        // route one item to each leg
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
        bus.in_sel   = LEG0;
        #1;
        check("route_ready0", bus.in_ready, 1);
        step();
        check("route_v0",   bus.out0_valid, 1);
        check("route_d0",   bus.out0_data,  1);
        check("route_cnt0", bus.cnt0,       1);
        check("route_busy", bus.busy,       1);
        check("route_st0",  bus.dbg_st0,    SLOT_FULL);
        bus.in_data = 1'b0;
        bus.in_sel  = LEG1;
        step();
        check("route_v1",    bus.out1_valid, 1);
        check("route_d1",    bus.out1_data,  0);
        check("route_cnt1",  bus.cnt1,       1);
        check("route_v0_dr", bus.out0_valid, 0);
        bus.in_valid = 1'b0;
        step();
        check("route_v1_dr", bus.out1_valid, 0);
        check("route_idle",  bus.busy,       0);

        // backpressure on leg 0
        bus.out0_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_sel     = LEG0;
        bus.in_data    = 1'b1;
        #1;
        check("bp_ready_first", bus.in_ready, 1);
        step();
        check("bp_v0",   bus.out0_valid, 1);
        check("bp_d0",   bus.out0_data,  1);
        check("bp_cnt0", bus.cnt0,       2);
        bus.in_data = 1'b0;
        #1;
        check("bp_ready_second", bus.in_ready, 0);
        step();
        check("bp_hold_v0",   bus.out0_valid, 1);
        check("bp_hold_d0",   bus.out0_data,  1);
        check("bp_hold_cnt0", bus.cnt0,       2);
        bus.out0_ready = 1'b1;
        #1;
        check("bp_ready_release", bus.in_ready, 1);
        step();
        check("bp_swap_v0",   bus.out0_valid, 1);
        check("bp_swap_d0",   bus.out0_data,  0);
        check("bp_swap_cnt0", bus.cnt0,       3);

        // leg 0 stalled full, leg 1 still accepts
        bus.out0_ready = 1'b0;
        bus.in_sel     = LEG1;
        bus.in_data    = 1'b1;
        #1;
        check("ind_ready", bus.in_ready, 1);
        step();
        check("ind_v1",   bus.out1_valid, 1);
        check("ind_d1",   bus.out1_data,  1);
        check("ind_v0",   bus.out0_valid, 1);
        check("ind_d0",   bus.out0_data,  0);
        check("ind_cnt0", bus.cnt0,       3);
        check("ind_cnt1", bus.cnt1,       2);
        bus.in_valid   = 1'b0;
        bus.out0_ready = 1'b1;
        step();
        check("ind_drained", bus.busy, 0);

        // counter wrap on leg 1
        do_reset();
        bus.out1_ready = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_sel     = LEG1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 1'(i);
            step();
            check($sformatf("wrap_cnt1_%0d", i), bus.cnt1, wrap_exp[i]);
        end
        bus.in_valid = 1'b0;
        step();
        check("wrap_cnt0", bus.cnt0, 0);

        // loopback into a 2:1 mux over all {a,b,c}
        for (int v = 0; v < 8; v++) begin
            vb = 3'(v);
            a  = vb[2];
            b  = vb[1];
            c  = vb[0];
            bus.in_valid   = 1'b0;
            bus.out0_ready = 1'b1;
            bus.out1_ready = 1'b1;
            step();
            bus.out0_ready = 1'b0;
            bus.out1_ready = 1'b0;
            bus.in_valid   = 1'b1;
            bus.in_sel     = LEG0;
            bus.in_data    = a;
            step();
            bus.in_sel  = LEG1;
            bus.in_data = b;
            step();
            bus.in_valid = 1'b0;
            bus.in_sel   = c;
            #1;
            z     = (c & bus.out1_data) | (bus.out0_data & ~c);
            exp_z = c ? b : a;
            check($sformatf("loop_z_%0d", v), z, exp_z);
            check($sformatf("loop_full_%0d", v), {bus.out0_valid, bus.out1_valid}, 2'b11);
        end
        check("loop_q0", exp0_q.size(), 1);
        check("loop_q1", exp1_q.size(), 1);

        // asynchronous reset with both legs full, mid-cycle
        rst_n = 1'b0;
        #1;
        check("async_v0",   bus.out0_valid, 0);
        check("async_v1",   bus.out1_valid, 0);
        check("async_busy", bus.busy,       0);
        check("async_cnt1", bus.cnt1,       0);
        exp0_q.delete();
        exp1_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
